mem_bus_arbiter: RTL and testbench
==================================

Name: mem_bus_arbiter

Overview:
- Shares one SRAM-style memory bus (addr_ok/data_ok handshake) between REQUESTERS masters, e.g. instruction fetch and data access.
- One outstanding bus transaction at a time.
- Winner is chosen by fixed priority or round-robin; the grant is held from address phase through data phase.
- Sits between the CPU core's fetch/memory stages and the external memory interface.

Parameters:
- REQUESTERS, 2, number of requester ports (>= 2).
- ADDR_WIDTH, 32, address width.
- DATA_WIDTH, 32, data width.
- ROUND_ROBIN, 1, 0 = fixed priority (index 0 highest); 1 = round-robin.

Ports:
- clock  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  REQUESTERS  per-requester request; held until its req_addr_ok.
- req_write  in  REQUESTERS  1 = write.
- req_size  in  2*REQUESTERS  byte count minus 1, slice i = [2i+1:2i].
- req_addr  in  ADDR_WIDTH*REQUESTERS  request address, slice i.
- req_wdata  in  DATA_WIDTH*REQUESTERS  write data, slice i.
- req_addr_ok  out  REQUESTERS  one-hot pulse: address phase accepted.
- req_data_ok  out  REQUESTERS  one-hot pulse: data phase done.
- req_rdata  out  DATA_WIDTH  read data, broadcast, valid with req_data_ok.
- bus_req  out  1  bus request.
- bus_write  out  1  bus write.
- bus_size  out  2  bus size.
- bus_addr  out  ADDR_WIDTH  bus address.
- bus_wdata  out  DATA_WIDTH  bus write data.
- bus_addr_ok  in  1  slave accepted address.
- bus_data_ok  in  1  slave finished data phase.
- bus_rdata  in  DATA_WIDTH  slave read data.
- busy  out  1  state != IDLE.
- grant_id  out  $clog2(REQUESTERS)  index of current owner; 0 in IDLE.

Behaviour:
- Reset values: state IDLE, rr_ptr = 0, grant_id = 0, busy = 0.
- Reset values (bus side): bus_req = 0, bus_write = 0, bus_size = 0, bus_addr = 0, bus_wdata = 0.
- Reset values (requester side): req_addr_ok = 0, req_data_ok = 0. req_rdata follows bus_rdata.
- FSM IDLE:
  - If any req_valid, select winner W and register W into grant_id.
  - Latch req_write/size/addr/wdata of W into the bus_* registers; next state ADDR.
  - Otherwise stay in IDLE.
  - Latency: req_valid sampled high in IDLE -> bus_req = 1 on the next cycle.
- Winner selection, ROUND_ROBIN = 0: lowest index with req_valid set.
- Winner selection, ROUND_ROBIN = 1:
  - W is the first set req_valid scanning rr_ptr, rr_ptr+1, ... with wrap modulo REQUESTERS.
  - On grant, rr_ptr <= (W+1) mod REQUESTERS.
- FSM ADDR:
  - bus_req = 1; bus_* fields are stable registers.
  - When bus_addr_ok = 1: req_addr_ok[grant_id] = 1 in the same cycle (combinational), bus_req drops next cycle, next state DATA.
- FSM DATA:
  - bus_req = 0.
  - When bus_data_ok = 1: req_data_ok[grant_id] = 1 in the same cycle and req_rdata = bus_rdata; next state IDLE.
- No back-to-back grant: exactly one IDLE cycle between transactions. Minimum transaction is 3 cycles (IDLE, ADDR, DATA).
- Ignored inputs and outputs outside their phase:
  - bus_data_ok is ignored outside DATA; bus_addr_ok is ignored outside ADDR.
  - req_addr_ok/req_data_ok are never asserted for a non-granted index.
- Requester contract:
  - Fields are captured once in IDLE; later changes before addr_ok are ignored.
  - The granted requester's req_valid is not rechecked in ADDR; the bus request completes regardless.
- Simultaneous requests: only W is served. Losers keep req_valid high and are arbitrated in the next IDLE.
- Reset mid-operation: immediately (asynchronously) returns to IDLE with reset output values. The in-flight bus transaction is abandoned, and the slave is reset by the same signal.
- Width rule: grant_id width is $clog2(REQUESTERS); rr_ptr wraps from REQUESTERS-1 to 0, including non-power-of-two counts.

Test Plan:
- Single read: req_valid = 01, addr 0x1000, size 3. Bus_addr_ok arrives 2 cycles after bus_req, bus_data_ok 3 cycles after that with rdata 0xDEADBEEF. Required: bus_req 1 cycle after req_valid, bus_addr = 0x1000, req_addr_ok = 01 pulse, req_data_ok = 01 pulse with req_rdata = 0xDEADBEEF.
- Fixed priority (ROUND_ROBIN = 0): req_valid = 11 held continuously, slave always ready. Required: requester 0 is granted every transaction, requester 1 never.
- Round-robin (ROUND_ROBIN = 1, REQUESTERS = 3): req_valid = 111 held. Required: grant_id sequence 0, 1, 2, 0, with one IDLE cycle between transactions.
- Write pass-through: requester 1 writes addr 0x2004, wdata 0x12345678, size 1. Required: bus_write = 1, bus_size = 1, bus_wdata = 0x12345678; requester 0 sees no ok pulses.
- Stray and late inputs: bus_data_ok pulsed during ADDR -> no req_data_ok. Requester changes req_addr during ADDR -> bus_addr unchanged.
- Reset in DATA: assert reset mid-DATA. Required: busy = 0 and bus_req = 0 before the next clock edge, rr_ptr = 0. After release with req_valid = 10, requester 1 is granted.

Source files
------------

// File: rtl/mem_bus_arbiter_if.sv
// Requester-side and memory-bus-side signals of the shared SRAM-style bus.
// The arbiter owns the memory bus (master view); the environment holds the
// requesters and the memory slave (slave view).
interface mem_bus_arbiter_if #(
    parameter int REQUESTERS = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [REQUESTERS-1:0]            req_valid;
    logic [REQUESTERS-1:0]            req_write;
    logic [2*REQUESTERS-1:0]          req_size;
    logic [ADDR_WIDTH*REQUESTERS-1:0] req_addr;
    logic [DATA_WIDTH*REQUESTERS-1:0] req_wdata;
    logic [REQUESTERS-1:0]            req_addr_ok;
    logic [REQUESTERS-1:0]            req_data_ok;
    logic [DATA_WIDTH-1:0]            req_rdata;

    logic                             bus_req;
    logic                             bus_write;
    logic [1:0]                       bus_size;
    logic [ADDR_WIDTH-1:0]            bus_addr;
    logic [DATA_WIDTH-1:0]            bus_wdata;
    logic                             bus_addr_ok;
    logic                             bus_data_ok;
    logic [DATA_WIDTH-1:0]            bus_rdata;

    modport master (
        input  req_valid, req_write, req_size, req_addr, req_wdata,
        output req_addr_ok, req_data_ok, req_rdata,
        output bus_req, bus_write, bus_size, bus_addr, bus_wdata,
        input  bus_addr_ok, bus_data_ok, bus_rdata
    );

    modport slave (
        output req_valid, req_write, req_size, req_addr, req_wdata,
        input  req_addr_ok, req_data_ok, req_rdata,
        input  bus_req, bus_write, bus_size, bus_addr, bus_wdata,
        output bus_addr_ok, bus_data_ok, bus_rdata
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Shares one addr_ok/data_ok memory bus between REQUESTERS masters, one
// outstanding transaction at a time. The grant is held from the address
// phase through the data phase, with one IDLE cycle between transactions.
module mem_bus_arbiter #(
    parameter int REQUESTERS  = 2,
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int ROUND_ROBIN = 1,
    localparam int GW         = (REQUESTERS > 1) ? $clog2(REQUESTERS) : 1
) (
    input  logic                clock,
    input  logic                reset,
    mem_bus_arbiter_if.master   mb,
    output logic                busy,
    output logic [GW-1:0]       grant_id
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic [GW-1:0]          rr_ptr;
    logic [GW-1:0]          rr_nxt;
    logic [GW-1:0]          winner;
    logic                   any_valid;
    int unsigned            scan_idx;

    logic                   write_r;
    logic [1:0]             size_r;
    logic [ADDR_WIDTH-1:0]  addr_r;
    logic [DATA_WIDTH-1:0]  wdata_r;

    // Winner: first valid requester scanning upward from rr_ptr (round-robin)
    // or from index 0 (fixed priority), wrapping modulo REQUESTERS.
    always_comb begin
        winner    = '0;
        any_valid = 1'b0;
        scan_idx  = 0;
        for (int unsigned k = 0; k < 32'(REQUESTERS); k++) begin
            if (ROUND_ROBIN != 0) begin
                scan_idx = (k + 32'(rr_ptr)) % 32'(REQUESTERS);
            end else begin
                scan_idx = k;
            end
            if (!any_valid && mb.req_valid[GW'(scan_idx)]) begin
                any_valid = 1'b1;
                winner    = GW'(scan_idx);
            end
        end
        // Explicit wrap keeps non-power-of-two counts in range.
        rr_nxt = (winner == GW'(REQUESTERS - 1)) ? '0 : winner + 1'b1;
    end

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and per-phase handshake outputs toward bus and requesters.
    always_comb begin
        state_nxt      = state;
        busy           = 1'b1;
        mb.bus_req     = 1'b0;
        mb.req_addr_ok = '0;
        mb.req_data_ok = '0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (any_valid) begin
                    state_nxt = ADDR;
                end
            end
            ADDR: begin
                mb.bus_req = 1'b1;
                if (mb.bus_addr_ok) begin
                    mb.req_addr_ok[grant_id] = 1'b1;
                    state_nxt                = DATA;
                end
            end
            DATA: begin
                if (mb.bus_data_ok) begin
                    mb.req_data_ok[grant_id] = 1'b1;
                    state_nxt                = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Capture the winner's request fields and owner id when leaving IDLE;
    // the owner id returns to 0 as the data phase completes.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            grant_id <= '0;
            rr_ptr   <= '0;
            write_r  <= 1'b0;
            size_r   <= '0;
            addr_r   <= '0;
            wdata_r  <= '0;
        end else if (state == IDLE && any_valid) begin
            grant_id <= winner;
            write_r  <= mb.req_write[winner];
            size_r   <= mb.req_size[2*winner +: 2];
            addr_r   <= mb.req_addr[ADDR_WIDTH*winner +: ADDR_WIDTH];
            wdata_r  <= mb.req_wdata[DATA_WIDTH*winner +: DATA_WIDTH];
            if (ROUND_ROBIN != 0) begin
                rr_ptr <= rr_nxt;
            end
        end else if (state == DATA && mb.bus_data_ok) begin
            grant_id <= '0;
        end
    end

    assign mb.bus_write = write_r;
    assign mb.bus_size  = size_r;
    assign mb.bus_addr  = addr_r;
    assign mb.bus_wdata = wdata_r;
    assign mb.req_rdata = mb.bus_rdata;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: a 3-requester round-robin instance and a
// 2-requester fixed-priority instance share clock and reset.
module tb_mem_bus_arbiter;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    mem_bus_arbiter_if #(.REQUESTERS(3), .ADDR_WIDTH(32), .DATA_WIDTH(32)) ifa ();
    mem_bus_arbiter_if #(.REQUESTERS(2), .ADDR_WIDTH(32), .DATA_WIDTH(32)) ifb ();

    logic       busy_a;
    logic [1:0] gid_a;
    logic       busy_b;
    logic [0:0] gid_b;

    mem_bus_arbiter #(.REQUESTERS(3), .ADDR_WIDTH(32), .DATA_WIDTH(32), .ROUND_ROBIN(1)) dut_a (
        .clock(clock), .reset(reset), .mb(ifa), .busy(busy_a), .grant_id(gid_a)
    );

    mem_bus_arbiter #(.REQUESTERS(2), .ADDR_WIDTH(32), .DATA_WIDTH(32), .ROUND_ROBIN(0)) dut_b (
        .clock(clock), .reset(reset), .mb(ifb), .busy(busy_b), .grant_id(gid_b)
    );

    int checks = 0;
    int errors = 0;

    // Reference model of the round-robin instance's requesters.
    logic [2:0]  pend;
    logic        m_write [3];
    logic [1:0]  m_size  [3];
    logic [31:0] m_addr  [3];
    logic [31:0] m_wdata [3];
    int          ptr;

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic drive_a;
        for (int i = 0; i < 3; i++) begin
            ifa.req_valid[i]          = pend[i];
            ifa.req_write[i]          = m_write[i];
            ifa.req_size[2*i +: 2]    = m_size[i];
            ifa.req_addr[32*i +: 32]  = m_addr[i];
            ifa.req_wdata[32*i +: 32] = m_wdata[i];
        end
    endtask

    function automatic int pick();
        for (int k = 0; k < 3; k++) begin
            if (pend[(ptr + k) % 3]) return (ptr + k) % 3;
        end
        return -1;
    endfunction

    task automatic new_req(input int i, input logic wr, input logic [1:0] sz,
                           input logic [31:0] ad, input logic [31:0] wd);
        pend[i]    = 1'b1;
        m_write[i] = wr;
        m_size[i]  = sz;
        m_addr[i]  = ad;
        m_wdata[i] = wd;
    endtask

    // One full transaction on instance A, starting from an IDLE cycle.
    task automatic run_txn_a(input int alat, input int dlat, input logic [31:0] rdata,
                             input bit stray, input bit late, output int gobs);
        int w;
        w   = pick();
        ptr = (w + 1) % 3;
        drive_a();
        tick();
        gobs = int'(gid_a);
        checks++;
        if (busy_a !== 1'b1 || ifa.bus_req !== 1'b1)
            begin errors++; $display("FAIL addr_phase: busy=%b bus_req=%b want 1 1", busy_a, ifa.bus_req); end
        checks++;
        if (gid_a !== w[1:0])
            begin errors++; $display("FAIL grant_id: got %0d want %0d", gid_a, w); end
        checks++;
        if ({ifa.bus_write, ifa.bus_size, ifa.bus_addr, ifa.bus_wdata} !== {m_write[w], m_size[w], m_addr[w], m_wdata[w]})
            begin errors++; $display("FAIL bus_fields: got w=%b s=%0d a=%h d=%h want w=%b s=%0d a=%h d=%h",
                ifa.bus_write, ifa.bus_size, ifa.bus_addr, ifa.bus_wdata, m_write[w], m_size[w], m_addr[w], m_wdata[w]); end
        if (late) ifa.req_addr[32*w +: 32] = ~m_addr[w];
        for (int j = 0; j < alat; j++) begin
            ifa.bus_data_ok = stray;
            #1;
            checks++;
            if (ifa.req_addr_ok !== 3'b000 || ifa.req_data_ok !== 3'b000 || ifa.bus_req !== 1'b1 || ifa.bus_addr !== m_addr[w])
                begin errors++; $display("FAIL addr_wait: aok=%b dok=%b bus_req=%b addr=%h want 000 000 1 %h",
                    ifa.req_addr_ok, ifa.req_data_ok, ifa.bus_req, ifa.bus_addr, m_addr[w]); end
            tick();
        end
        ifa.bus_data_ok = 1'b0;
        ifa.bus_addr_ok = 1'b1;
        #1;
        checks++;
        if (ifa.req_addr_ok !== 3'(1 << w) || ifa.req_data_ok !== 3'b000 || ifa.bus_addr !== m_addr[w])
            begin errors++; $display("FAIL addr_ok: aok=%b dok=%b addr=%h want %b 000 %h",
                ifa.req_addr_ok, ifa.req_data_ok, ifa.bus_addr, 3'(1 << w), m_addr[w]); end
        tick();
        ifa.bus_addr_ok = 1'b0;
        pend[w] = 1'b0;
        drive_a();
        checks++;
        if (ifa.bus_req !== 1'b0 || busy_a !== 1'b1 || gid_a !== w[1:0])
            begin errors++; $display("FAIL data_phase: bus_req=%b busy=%b gid=%0d want 0 1 %0d", ifa.bus_req, busy_a, gid_a, w); end
        for (int j = 0; j < dlat; j++) begin
            ifa.bus_addr_ok = stray;
            #1;
            checks++;
            if (ifa.req_addr_ok !== 3'b000 || ifa.req_data_ok !== 3'b000 || ifa.bus_req !== 1'b0)
                begin errors++; $display("FAIL data_wait: aok=%b dok=%b bus_req=%b want 000 000 0",
                    ifa.req_addr_ok, ifa.req_data_ok, ifa.bus_req); end
            tick();
        end
        ifa.bus_addr_ok = 1'b0;
        ifa.bus_data_ok = 1'b1;
        ifa.bus_rdata   = rdata;
        #1;
        checks++;
        if (ifa.req_data_ok !== 3'(1 << w) || ifa.req_addr_ok !== 3'b000 || ifa.req_rdata !== rdata)
            begin errors++; $display("FAIL data_ok: dok=%b aok=%b rdata=%h want %b 000 %h",
                ifa.req_data_ok, ifa.req_addr_ok, ifa.req_rdata, 3'(1 << w), rdata); end
        tick();
        ifa.bus_data_ok = 1'b0;
        checks++;
        if (busy_a !== 1'b0 || ifa.bus_req !== 1'b0 || gid_a !== 2'd0)
            begin errors++; $display("FAIL idle_gap: busy=%b bus_req=%b gid=%0d want 0 0 0", busy_a, ifa.bus_req, gid_a); end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        pend = '0;
        for (int i = 0; i < 3; i++) begin
            m_write[i] = 1'b0; m_size[i] = '0; m_addr[i] = '0; m_wdata[i] = '0;
        end
        ptr = 0;
        drive_a();
        ifa.bus_addr_ok = 1'b0; ifa.bus_data_ok = 1'b0; ifa.bus_rdata = 32'h55AA_1234;
        ifb.req_valid = '0; ifb.req_write = '0; ifb.req_size = '0; ifb.req_addr = '0; ifb.req_wdata = '0;
        ifb.bus_addr_ok = 1'b0; ifb.bus_data_ok = 1'b0; ifb.bus_rdata = '0;
        pend = 3'b001;
        drive_a();
        tick();
        tick();
        checks++;
        if (busy_a !== 1'b0 || gid_a !== 2'd0 || ifa.bus_req !== 1'b0 || ifa.bus_write !== 1'b0 || ifa.bus_size !== 2'd0)
            begin errors++; $display("FAIL reset_ctl: busy=%b gid=%0d req=%b wr=%b sz=%0d want all 0",
                busy_a, gid_a, ifa.bus_req, ifa.bus_write, ifa.bus_size); end
        checks++;
        if (ifa.bus_addr !== 32'h0 || ifa.bus_wdata !== 32'h0 || ifa.req_addr_ok !== 3'b000 || ifa.req_data_ok !== 3'b000)
            begin errors++; $display("FAIL reset_data: addr=%h wdata=%h aok=%b dok=%b want all 0",
                ifa.bus_addr, ifa.bus_wdata, ifa.req_addr_ok, ifa.req_data_ok); end
        checks++;
        if (ifa.req_rdata !== 32'h55AA_1234 || busy_b !== 1'b0 || ifb.bus_req !== 1'b0)
            begin errors++; $display("FAIL reset_misc: rdata=%h busy_b=%b req_b=%b want 55aa1234 0 0",
                ifa.req_rdata, busy_b, ifb.bus_req); end
        pend = '0;
        drive_a();
        @(negedge clock);
        reset = 1'b0;
        tick();
        checks++;
        if (busy_a !== 1'b0 || ifa.bus_req !== 1'b0)
            begin errors++; $display("FAIL post_reset_idle: busy=%b bus_req=%b want 0 0", busy_a, ifa.bus_req); end
    endtask

    task automatic test_single_read;
        int g;
        new_req(0, 1'b0, 2'd3, 32'h0000_1000, 32'h0);
        run_txn_a(2, 3, 32'hDEAD_BEEF, 1'b0, 1'b0, g);
    endtask

    task automatic test_write;
        int g;
        new_req(1, 1'b1, 2'd1, 32'h0000_2004, 32'h1234_5678);
        run_txn_a(1, 1, $urandom, 1'b0, 1'b0, g);
    endtask

    task automatic test_stray_late;
        int g;
        new_req(2, 1'($urandom), 2'($urandom), $urandom, $urandom);
        run_txn_a(2, 2, $urandom, 1'b1, 1'b1, g);
    endtask

    task automatic test_round_robin;
        int g;
        int exp_seq [4] = '{0, 1, 2, 0};
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        ptr = 0;
        for (int i = 0; i < 3; i++) new_req(i, 1'b0, 2'd3, 32'h100 * (i + 1), 32'h0);
        tick();
        for (int n = 0; n < 4; n++) begin
            run_txn_a(0, 0, $urandom, 1'b0, 1'b0, g);
            checks++;
            if (g !== exp_seq[n])
                begin errors++; $display("FAIL rr_seq[%0d]: got %0d want %0d", n, g, exp_seq[n]); end
            pend[g] = 1'b1;
        end
        pend = '0;
        drive_a();
    endtask

    task automatic test_fixed_priority;
        int n_data0 = 0;
        ifb.req_addr    = {32'h0000_00B1, 32'h0000_00B0};
        ifb.req_valid   = 2'b11;
        ifb.bus_addr_ok = 1'b1;
        ifb.bus_data_ok = 1'b1;
        ifb.bus_rdata   = 32'hCAFE_0001;
        for (int c = 0; c < 12; c++) begin
            tick();
            checks++;
            if (ifb.req_addr_ok[1] !== 1'b0 || ifb.req_data_ok[1] !== 1'b0 || (busy_b && (gid_b !== 1'b0 || ifb.bus_addr !== 32'hB0)))
                begin errors++; $display("FAIL fixed_prio[%0d]: aok=%b dok=%b gid=%0d addr=%h want owner 0 addr b0",
                    c, ifb.req_addr_ok, ifb.req_data_ok, gid_b, ifb.bus_addr); end
            if (ifb.req_data_ok[0] === 1'b1) n_data0++;
        end
        ifb.req_valid = 2'b00;
        ifb.bus_addr_ok = 1'b0;
        ifb.bus_data_ok = 1'b0;
        checks++;
        if (n_data0 !== 4)
            begin errors++; $display("FAIL fixed_prio_count: got %0d want 4", n_data0); end
        tick();
    endtask

    task automatic test_reset_data;
        int g;
        new_req(1, 1'b0, 2'd2, 32'h0000_3000, 32'h0);
        pend[0] = 1'b0; pend[2] = 1'b0;
        ptr = 1;
        drive_a();
        tick();
        ifa.bus_addr_ok = 1'b1;
        tick();
        ifa.bus_addr_ok = 1'b0;
        pend = '0;
        drive_a();
        checks++;
        if (busy_a !== 1'b1 || ifa.bus_req !== 1'b0)
            begin errors++; $display("FAIL pre_reset_data: busy=%b bus_req=%b want 1 0", busy_a, ifa.bus_req); end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (busy_a !== 1'b0 || ifa.bus_req !== 1'b0 || gid_a !== 2'd0 || ifa.bus_addr !== 32'h0)
            begin errors++; $display("FAIL async_reset: busy=%b bus_req=%b gid=%0d addr=%h want 0 0 0 0",
                busy_a, ifa.bus_req, gid_a, ifa.bus_addr); end
        @(negedge clock);
        reset = 1'b0;
        ptr = 0;
        new_req(1, 1'b0, 2'd0, 32'h0000_4000, 32'h0);
        new_req(2, 1'b0, 2'd0, 32'h0000_5000, 32'h0);
        run_txn_a(1, 1, $urandom, 1'b0, 1'b0, g);
        checks++;
        if (g !== 1)
            begin errors++; $display("FAIL reset_rr_ptr: got owner %0d want 1", g); end
        run_txn_a(0, 0, $urandom, 1'b0, 1'b0, g);
    endtask

    task automatic test_random;
        int g;
        for (int t = 0; t < 40; t++) begin
            for (int i = 0; i < 3; i++) begin
                if (!pend[i] && ($urandom % 2 == 0))
                    new_req(i, 1'($urandom), 2'($urandom), $urandom, $urandom);
            end
            if (pend == 3'b000) new_req($urandom_range(0, 2), 1'($urandom), 2'($urandom), $urandom, $urandom);
            run_txn_a($urandom_range(0, 3), $urandom_range(0, 3), $urandom,
                      1'($urandom), 1'($urandom), g);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single_read();
        test_write();
        test_stray_late();
        test_round_robin();
        test_fixed_priority();
        test_reset_data();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
